// File: rtl/data_mem_responder_if.sv
// Request/response bus between the multicycle control unit and the data memory responder.
interface data_mem_if #(
  parameter int DATA_W = 32
);
  logic              rdMem;
  logic              wrMem;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              memBusy;
  logic              memDone;
  logic              memErr;

  modport master (
    output rdMem, wrMem, addr, wdata,
    input  rdata, memBusy, memDone, memErr
  );

  modport slave (
    input  rdMem, wrMem, addr, wdata,
    output rdata, memBusy, memDone, memErr
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store per strobe edge, inserts WAIT_CYC wait
// states, then performs the RAM access and pulses memDone. Bad requests pulse memErr.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a strobe edge; rejects bad requests with memErr
// ST_WAIT   | request latched, burning wait states (counter down to 0)
// ST_ACCESS | RAM read or write this edge, memDone next cycle
module data_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  data_mem_if.slave mem_if
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rd_q, wr_q;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   word_q, word_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                mem_we;
  logic                mem_re;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic rd_edge, wr_edge, misaligned, out_of_range;

  assign rd_edge      = mem_if.rdMem & ~rd_q;
  assign wr_edge      = mem_if.wrMem & ~wr_q;
  assign misaligned   = |mem_if.addr[1:0];
  assign out_of_range = |mem_if.addr[31:ADDR_W+2];

  assign mem_if.rdata   = rdata_q;
  assign mem_if.memBusy = busy_q;
  assign mem_if.memDone = done_q;
  assign mem_if.memErr  = err_q;

  // Next-state and output decode; completion/error pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_edge || wr_edge) begin
          if ((rd_edge && wr_edge) || misaligned || out_of_range) begin
            err_d = 1'b1;
          end else begin
            op_wr_d = wr_edge;
            word_d  = mem_if.addr[ADDR_W+1:2];
            wdata_d = mem_if.wdata;
            busy_d  = 1'b1;
            if (WAIT_CYC > 0) begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_LOAD;
            end else begin
              state_d = ST_ACCESS;
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: begin
        mem_we  = op_wr_q;
        mem_re  = ~op_wr_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= mem_if.rdMem;
      wr_q    <= mem_if.wrMem;
      op_wr_q <= op_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (mem_re) rdata_q <= mem_q[word_q];
    end
  end

  // RAM array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[word_q] <= wdata_q;
  end

endmodule
